// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx : UART transmitter with a one-entry holding register.
//
// Each accepted word is sent as one frame on uart_txd: one start bit (low),
// PAYLOAD_BITS data bits LSB first, then STOP_BITS stop bits (high). A BREAK
// request holds the line low for the start, data and stop-bit periods, and
// then sends STOP_BITS high periods. While one frame shifts out, the next
// word waits in the holding register. That word is loaded at the last cycle
// of the stop bits, so frames follow each other with no idle gap.
//
// Ports
//   clk           in   system clock
//   resetn        in   asynchronous active-low reset
//   uart_txd      out  registered TX line, idles high
//   uart_tx_en    in   send request, accepted when uart_tx_ready is high
//   uart_tx_data  in   PAYLOAD_BITS word, sampled on accept
//   uart_tx_break in   sampled on accept: 1 = send a BREAK frame
//   uart_tx_ready out  holding register empty
//   uart_tx_busy  out  frame in progress or word held
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    uart_txd,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  input  logic                    uart_tx_break,
  output logic                    uart_tx_ready,
  output logic                    uart_tx_busy
);

  localparam int BIT_P          = 1_000_000_000 / BIT_RATE;
  localparam int CLK_P          = 1_000_000_000 / CLK_HZ;
  localparam int CYCLES_PER_BIT = BIT_P / CLK_P;

  localparam logic [15:0] CYC_LAST  = 16'(CYCLES_PER_BIT - 1);
  localparam logic [3:0]  DATA_LAST = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_BREAK,
    ST_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             cycle_cnt_q, cycle_cnt_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [PAYLOAD_BITS-1:0] shifter_q, shifter_d;
  logic                    brk_q, brk_d;
  logic                    txd_q, txd_d;

  logic                    hold_valid_q;
  logic [PAYLOAD_BITS-1:0] hold_data_q;
  logic                    hold_brk_q;

  logic                    bit_end;
  logic                    load;
  logic                    accept;

  assign bit_end = (cycle_cnt_q == CYC_LAST);
  // accept needs an empty holding register and load needs a full one,
  // so the two can never happen at the same edge.
  assign accept  = uart_tx_en && !hold_valid_q;

  assign uart_txd      = txd_q;
  assign uart_tx_ready = !hold_valid_q;
  assign uart_tx_busy  = hold_valid_q || (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shifter_d   = shifter_q;
    brk_d       = brk_q;
    txd_d       = txd_q;
    load        = 1'b0;

    // Bit timing runs continuously from the START-entry edge, so
    // back-to-back frames do not accumulate drift.
    if (state_q != ST_IDLE) begin
      cycle_cnt_d = bit_end ? 16'd0 : cycle_cnt_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (hold_valid_q) begin
          load = 1'b1;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = 4'd0;
          txd_d     = !brk_q && shifter_q[0];
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = 4'd0;
            if (brk_q) begin
              state_d = ST_BREAK;
              txd_d   = 1'b0;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shifter_d = {1'b0, shifter_q[PAYLOAD_BITS-1:1]};
            // The next bit is shifter_q[1]; it moves to bit 0 at this edge.
            txd_d     = !brk_q && shifter_q[1];
          end
        end
      end

      ST_BREAK: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = 4'd0;
            state_d   = ST_STOP;
            txd_d     = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = 4'd0;
            if (hold_valid_q) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Loading the held word starts a new frame: the start bit is driven at
    // this same edge.
    if (load) begin
      state_d     = ST_START;
      shifter_d   = hold_data_q;
      brk_d       = hold_brk_q;
      txd_d       = 1'b0;
      cycle_cnt_d = 16'd0;
      bit_cnt_d   = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cycle_cnt_q  <= 16'd0;
      bit_cnt_q    <= 4'd0;
      shifter_q    <= '0;
      brk_q        <= 1'b0;
      txd_q        <= 1'b1;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_brk_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shifter_q   <= shifter_d;
      brk_q       <= brk_d;
      txd_q       <= txd_d;
      if (load) begin
        hold_valid_q <= 1'b0;
      end else if (accept) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= uart_tx_data;
        hold_brk_q   <= uart_tx_break;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx : self-checking bench for uart_tx with 10 clocks per bit,
// 8 data bits and 1 stop bit. A line-level model turns each accepted word
// into its expected per-cycle waveform and checks txd, ready and busy on
// every clock cycle. Literal checks at chosen cycles also fix the model.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CPB = 10;
  localparam int PB  = 8;
  localparam int SB  = 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          uart_txd;
  logic          uart_tx_en = 1'b0;
  logic [PB-1:0] uart_tx_data = '0;
  logic          uart_tx_break = 1'b0;
  logic          uart_tx_ready;
  logic          uart_tx_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  uart_tx #(
    .BIT_RATE    (5_000_000),
    .CLK_HZ      (50_000_000),
    .PAYLOAD_BITS(PB),
    .STOP_BITS   (SB)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .uart_txd     (uart_txd),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_break(uart_tx_break),
    .uart_tx_ready(uart_tx_ready),
    .uart_tx_busy (uart_tx_busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------------ model
  bit            q[$];
  logic          m_hold_v = 1'b0;
  logic [PB-1:0] m_hold_d = '0;
  logic          m_hold_b = 1'b0;
  logic          exp_txd = 1'b1;
  logic          exp_ready = 1'b1;
  logic          exp_busy = 1'b0;
  logic          was_hold;
  logic          popped;

  function automatic void push_frame(input logic [PB-1:0] d, input logic b);
    for (int i = 0; i < CPB; i++) q.push_back(1'b0);
    for (int j = 0; j < PB; j++)
      for (int i = 0; i < CPB; i++) q.push_back(b ? 1'b0 : d[j]);
    for (int s = 0; s < SB * CPB; s++) q.push_back(b ? 1'b0 : 1'b1);
    if (b)
      for (int s = 0; s < SB * CPB; s++) q.push_back(1'b1);
  endfunction

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      q.delete();
      m_hold_v  = 1'b0;
      exp_txd   = 1'b1;
      exp_ready = 1'b1;
      exp_busy  = 1'b0;
    end else begin
      was_hold = m_hold_v;
      popped   = 1'b0;
      if (q.size() == 0 && m_hold_v) begin
        push_frame(m_hold_d, m_hold_b);
        m_hold_v = 1'b0;
      end
      if (q.size() > 0) begin
        exp_txd = q.pop_front();
        popped  = 1'b1;
      end else begin
        exp_txd = 1'b1;
      end
      if (uart_tx_en && !was_hold) begin
        m_hold_v = 1'b1;
        m_hold_d = uart_tx_data;
        m_hold_b = uart_tx_break;
      end
      exp_ready = !m_hold_v;
      exp_busy  = m_hold_v || popped;
    end
  end

  initial forever begin
    @(negedge clk);
    if (resetn) begin
      check("txd",   uart_txd,      exp_txd);
      check("ready", uart_tx_ready, exp_ready);
      check("busy",  uart_tx_busy,  exp_busy);
    end
  end

  // --------------------------------------------------------------- helpers
  task automatic send(input logic [PB-1:0] d, input logic b, output int e0);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!uart_tx_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!uart_tx_ready) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL send_ready_timeout: ready=%b expected 1", uart_tx_ready);
    end
    uart_tx_en    = 1'b1;
    uart_tx_data  = d;
    uart_tx_break = b;
    @(posedge clk);
    @(negedge clk);
    uart_tx_en    = 1'b0;
    uart_tx_data  = ~d;   // later changes must not affect the frame
    uart_tx_break = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic async_reset_check(input string tag);
    #2 resetn = 1'b0;
    #1;
    check({tag, "_rst_txd"},   uart_txd,      1'b1);
    check({tag, "_rst_ready"}, uart_tx_ready, 1'b1);
    check({tag, "_rst_busy"},  uart_tx_busy,  1'b0);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    int e0, e1, ex;
    logic [PB-1:0] pat;

    repeat (3) @(negedge clk);
    check("init_txd",   uart_txd,      1'b1);
    check("init_ready", uart_tx_ready, 1'b1);
    check("init_busy",  uart_tx_busy,  1'b0);
    #2 resetn = 1'b1;
    repeat (5) @(negedge clk);

    // Single word 0xA5: expected line bits LSB first are 1,0,1,0,0,1,0,1
    pat = 8'b1010_0101;
    send(8'hA5, 1'b0, e0);
    e1 = e0 + 1;
    wait_until(e1 + 5);   check("a5_start", uart_txd, 1'b0);
    wait_until(e1 + 15);  check("a5_b0", uart_txd, 1'b1);
    wait_until(e1 + 25);  check("a5_b1", uart_txd, 1'b0);
    wait_until(e1 + 35);  check("a5_b2", uart_txd, 1'b1);
    wait_until(e1 + 65);  check("a5_b5", uart_txd, pat[5]);
    wait_until(e1 + 85);  check("a5_b7", uart_txd, 1'b1);
    wait_until(e1 + 95);  check("a5_stop", uart_txd, 1'b1);
    wait_until(e1 + 99);  check("a5_busy_last", uart_tx_busy, 1'b1);
    wait_until(e1 + 100); check("a5_busy_fall", uart_tx_busy, 1'b0);
    repeat (5) @(negedge clk);

    // Back-to-back 0x00 then 0xFF, with an overrun attempt while held
    send(8'h00, 1'b0, e0);
    e1 = e0 + 1;
    wait_until(e1 + 30);
    send(8'hFF, 1'b0, ex);
    check("b2b_ready_low", uart_tx_ready, 1'b0);
    uart_tx_en    = 1'b1;
    uart_tx_data  = 8'h55;
    uart_tx_break = 1'b1;
    wait_until(e1 + 60);
    uart_tx_en    = 1'b0;
    uart_tx_break = 1'b0;
    wait_until(e1 + 99);  check("b2b_ready_99", uart_tx_ready, 1'b0);
                          check("b2b_stop1", uart_txd, 1'b1);
    wait_until(e1 + 100); check("b2b_ready_100", uart_tx_ready, 1'b1);
                          check("b2b_start2", uart_txd, 1'b0);
                          check("b2b_busy", uart_tx_busy, 1'b1);
    wait_until(e1 + 115); check("b2b_ff_b0", uart_txd, 1'b1);
    wait_until(e1 + 155); check("b2b_ff_b4", uart_txd, 1'b1);
    wait_until(e1 + 199); check("b2b_busy_199", uart_tx_busy, 1'b1);
    wait_until(e1 + 200); check("b2b_busy_200", uart_tx_busy, 1'b0);
                          check("b2b_idle_txd", uart_txd, 1'b1);
    repeat (5) @(negedge clk);

    // BREAK with data 0xFF
    send(8'hFF, 1'b1, e0);
    e1 = e0 + 1;
    wait_until(e1 + 5);   check("brk_start", uart_txd, 1'b0);
    wait_until(e1 + 50);  check("brk_mid", uart_txd, 1'b0);
                          check("brk_busy_mid", uart_tx_busy, 1'b1);
    wait_until(e1 + 99);  check("brk_low_end", uart_txd, 1'b0);
    wait_until(e1 + 100); check("brk_stop", uart_txd, 1'b1);
    wait_until(e1 + 109); check("brk_busy_109", uart_tx_busy, 1'b1);
    wait_until(e1 + 110); check("brk_busy_110", uart_tx_busy, 1'b0);
    repeat (5) @(negedge clk);

    // Asynchronous reset while the line is low and a word is held
    send(8'h00, 1'b0, e0);
    e1 = e0 + 1;
    send(8'h0F, 1'b0, ex);
    wait_until(e1 + 15);
    check("r1_pre_txd", uart_txd, 1'b0);
    check("r1_pre_ready", uart_tx_ready, 1'b0);
    async_reset_check("r1");
    repeat (20) @(negedge clk);
    check("r1_idle_txd", uart_txd, 1'b1);
    check("r1_idle_busy", uart_tx_busy, 1'b0);

    // Reset mid-frame at cycle 35 of 0x3C, then a clean 0x81
    send(8'h3C, 1'b0, e0);
    e1 = e0 + 1;
    send(8'h0F, 1'b0, ex);
    wait_until(e1 + 35);
    async_reset_check("r2");
    repeat (5) @(negedge clk);
    send(8'h81, 1'b0, e0);
    e1 = e0 + 1;
    wait_until(e1 + 5);   check("x81_start", uart_txd, 1'b0);
    wait_until(e1 + 15);  check("x81_b0", uart_txd, 1'b1);
    wait_until(e1 + 25);  check("x81_b1", uart_txd, 1'b0);
    wait_until(e1 + 45);  check("x81_b3", uart_txd, 1'b0);
    wait_until(e1 + 85);  check("x81_b7", uart_txd, 1'b1);
    wait_until(e1 + 100); check("x81_busy_fall", uart_tx_busy, 1'b0);
    repeat (20) @(negedge clk);
    check("x81_no_remnant", uart_tx_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter, the transmit-side counterpart of the existing UART receiver.
- Serialises one PAYLOAD_BITS word per frame onto uart_txd: start bit low, data LSB first, STOP_BITS stop bits high.
- A one-entry holding register lets the next word be queued while the current frame shifts out, giving gap-free back-to-back frames.
- Also generates line BREAK conditions. Sits between system logic and the TX pin.

Parameters:
- BIT_RATE, 9600: line bit rate in bits/s.
- CLK_HZ, 50_000_000: clk frequency in Hz.
- PAYLOAD_BITS, 8: data bits per frame. Legal range 5..9.
- STOP_BITS, 1: stop bits per frame. Legal values 1 or 2.

Ports:
- clk  input  1  top level system clock.
- resetn  input  1  asynchronous active-low reset.
- uart_txd  output  1  UART transmit pin, registered, idles high.
- uart_tx_en  input  1  send request; word accepted when uart_tx_en && uart_tx_ready at a rising edge.
- uart_tx_data  input  PAYLOAD_BITS  word to send, sampled on accept.
- uart_tx_break  input  1  sampled on accept; 1 = send a BREAK frame, data ignored.
- uart_tx_ready  output  1  holding register empty; a request is accepted this cycle.
- uart_tx_busy  output  1  frame in progress or word held.

Behaviour:
- Timing constants:
  - BIT_P = 1_000_000_000/BIT_RATE ns and CLK_P = 1_000_000_000/CLK_HZ ns, integer division.
  - CYCLES_PER_BIT = BIT_P/CLK_P. Must be >=2 and <65536.
  - Cycle counter is 16 bits; bit counter is 4 bits.
- Reset (asynchronous, any time, including mid-frame):
  - uart_txd=1, uart_tx_ready=1, uart_tx_busy=0, FSM=IDLE.
  - Holding register, its break flag, shifter and counters are cleared.
  - The partial frame is abandoned; no completion is signalled.
- Holding register:
  - uart_tx_ready = !hold_valid.
  - Accept at edge E0: hold_data<=uart_tx_data, hold_brk<=uart_tx_break, hold_valid<=1.
  - uart_tx_en while ready=0 is ignored: no state change, held word unchanged.
  - uart_tx_busy = hold_valid || FSM!=IDLE.
- FSM states: IDLE, START, DATA, BREAK, STOP.
  - IDLE: uart_txd=1. If hold_valid at an edge: shifter<=hold_data, brk<=hold_brk, hold_valid<=0, go to START, uart_txd<=0 at that same edge (E1 = E0+1 when idle).
  - START: txd=0 for CYCLES_PER_BIT cycles, then DATA.
  - DATA:
    - Each bit is held exactly CYCLES_PER_BIT cycles, LSB first; shifter shifts right at each bit boundary.
    - If brk, txd=0 for all PAYLOAD_BITS bits.
    - After PAYLOAD_BITS bits: go to BREAK if brk, else STOP.
  - BREAK: txd=0 for STOP_BITS bit periods, then STOP.
  - STOP: txd=1 for STOP_BITS bit periods.
    - At the final cycle, if hold_valid: load it and enter START directly, with txd low on the very next cycle and no idle gap.
    - Else go to IDLE.
- Frame lengths:
  - Normal frame: (1+PAYLOAD_BITS+STOP_BITS)*CYCLES_PER_BIT cycles.
  - BREAK frame: (1+PAYLOAD_BITS+STOP_BITS) bit periods low, then STOP_BITS periods high.
- Edge cases:
  - Hold drains at the edge where FSM loads it; ready rises the cycle after.
  - No simultaneous accept/drain conflict is possible, because ready=0 while hold_valid=1.
  - uart_tx_data may change freely after accept; the frame uses the sampled value.
  - Bit boundaries are counted from the START-entry edge; there is no drift across back-to-back frames.

Test Plan:
(Common setup: BIT_RATE=5_000_000, CLK_HZ=50_000_000, giving CYCLES_PER_BIT=10; PAYLOAD_BITS=8, STOP_BITS=1.)
1. Reset: assert resetn=0 mid-simulation -> uart_txd=1, uart_tx_ready=1, uart_tx_busy=0 immediately, without waiting for a clk edge.
2. Single word 0xA5, accepted at E0 ->
   - txd low from E1 for 10 cycles.
   - Then 1,0,1,0,0,1,0,1, each 10 cycles.
   - Then high 10 cycles; busy falls exactly 100 cycles after E1.
3. Back-to-back: send 0x00, then 0xFF while the first frame is in DATA ->
   - ready=0 from the second accept until the STOP-end reload.
   - Second start bit immediately follows the first stop bit; 200 contiguous cycles, no idle gap.
4. Overrun: third request while ready=0 -> ignored; only the two accepted frames appear on the line, and the held word is not corrupted.
5. BREAK: accept with uart_tx_break=1, data=0xFF -> txd low 100 cycles from E1, then high 10 cycles, then idle; busy high throughout.
6. Reset mid-frame: send 0x3C and assert resetn=0 at cycle 35 -> txd=1 at once; after release, send 0x81 -> clean correct frame, with no remnant of 0x3C or of a held word.
